light_nlvl_dimmer: RTL and testbench



---
 rtl/light_pkg.sv | 24 ++
 rtl/btn_debounce.sv | 46 ++++
 rtl/light_nlvl_dimmer.sv | 121 ++++++++++++
 tb/tb_light_nlvl_dimmer.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/light_pkg.sv
// Shared defaults and helpers for the N-level light dimmer.
package light_pkg;

  localparam int unsigned LEVELS_DEF     = 4;
  localparam int unsigned DEB_CYCLES_DEF = 4;
  localparam int unsigned THERM_MAX      = 32;

  typedef enum logic [1:0] {
    STEP_HOLD = 2'd0,
    STEP_UP   = 2'd1,
    STEP_DOWN = 2'd2
  } step_e;

  // Bit i set when lvl > i; callers size-cast to their bus width.
  function automatic logic [THERM_MAX-1:0] level_to_therm(input logic [31:0] lvl);
    logic [THERM_MAX-1:0] t;
    t = '0;
    for (int unsigned i = 0; i < THERM_MAX; i++) begin
      t[i] = (lvl > i);
    end
    return t;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser, counting debouncer and rising-edge press pulse
// for one raw push-button.
module btn_debounce
  import light_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic deb,
  output logic press
);

  localparam int unsigned CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

  logic          s1;
  logic          s2;
  logic          deb_q;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      deb   <= 1'b0;
      deb_q <= 1'b0;
      cnt   <= '0;
    end else begin
      s1    <= raw;
      s2    <= s1;
      deb_q <= deb;
      if (s2 == deb) begin
        cnt <= '0;
      end else if (cnt == CW'(DEB_CYCLES - 1)) begin
        cnt <= '0;
        deb <= s2;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  assign press = deb & ~deb_q;

endmodule

// File: rtl/light_nlvl_dimmer.sv
// N-level light controller: debounced up/down buttons step a saturating
// level, shown as binary, thermometer and PWM, with optional hold-to-repeat.
module light_nlvl_dimmer
  import light_pkg::*;
#(
  parameter int unsigned LEVELS        = LEVELS_DEF,
  parameter int unsigned DEB_CYCLES    = DEB_CYCLES_DEF,
  parameter int unsigned REPEAT_CYCLES = 0,
  parameter int unsigned LW            = $clog2(LEVELS + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              btn_up,
  input  logic              btn_down,
  output logic [LW-1:0]     level,
  output logic [LEVELS-1:0] light,
  output logic              pwm_out,
  output logic              at_max,
  output logic              at_min
);

  localparam int unsigned PW = $clog2(LEVELS);

  logic  up_deb, up_press, dn_deb, dn_press;
  logic  up_rpt, dn_rpt;
  logic  up_ev, dn_ev;
  step_e step;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_up (
    .clk   (clk),
    .reset (reset),
    .raw   (btn_up),
    .deb   (up_deb),
    .press (up_press)
  );

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_down (
    .clk   (clk),
    .reset (reset),
    .raw   (btn_down),
    .deb   (dn_deb),
    .press (dn_press)
  );

  generate
    if (REPEAT_CYCLES > 0) begin : g_rpt
      localparam int unsigned RW = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
      logic [RW-1:0] rpt_cnt;
      logic          rpt_active;
      logic          alone;
      logic          tick;

      assign alone = up_deb ^ dn_deb;
      assign tick  = rpt_active & alone & ~(up_press | dn_press) &
                     (rpt_cnt == RW'(REPEAT_CYCLES - 1));

      // Armed only by a press with one button alone; both-held or release disarms.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          rpt_cnt    <= '0;
          rpt_active <= 1'b0;
        end else if (!alone) begin
          rpt_cnt    <= '0;
          rpt_active <= 1'b0;
        end else if (up_press | dn_press) begin
          rpt_cnt    <= '0;
          rpt_active <= 1'b1;
        end else if (rpt_active) begin
          rpt_cnt <= tick ? '0 : rpt_cnt + RW'(1);
        end
      end

      assign up_rpt = tick & up_deb;
      assign dn_rpt = tick & dn_deb;
    end else begin : g_no_rpt
      assign up_rpt = 1'b0;
      assign dn_rpt = 1'b0;
    end
  endgenerate

  assign up_ev = up_press | up_rpt;
  assign dn_ev = dn_press | dn_rpt;

  always_comb begin
    step = STEP_HOLD;
    if (up_ev && !dn_ev && (level != LW'(LEVELS))) begin
      step = STEP_UP;
    end else if (dn_ev && !up_ev && (level != '0)) begin
      step = STEP_DOWN;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      level <= '0;
    end else begin
      case (step)
        STEP_UP:   level <= level + LW'(1);
        STEP_DOWN: level <= level - LW'(1);
        default:   level <= level;
      endcase
    end
  end

  logic [PW-1:0] pwm_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pwm_cnt <= '0;
      pwm_out <= 1'b0;
    end else begin
      pwm_cnt <= (pwm_cnt == PW'(LEVELS - 1)) ? '0 : pwm_cnt + PW'(1);
      pwm_out <= (LW'(pwm_cnt) < level);
    end
  end

  assign light  = LEVELS'(level_to_therm(32'(level)));
  assign at_max = (level == LW'(LEVELS));
  assign at_min = (level == '0);

endmodule

// File: tb/tb_light_nlvl_dimmer.sv
// Randomised and directed bench for light_nlvl_dimmer against a behavioural
// model; one instance without and one with auto-repeat share the buttons.
module tb_light_nlvl_dimmer;

  localparam int L  = 4;
  localparam int DB = 4;
  localparam int RP = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic       btn_up, btn_down;
  logic [2:0] lvl_a, lvl_b;
  logic [3:0] light_a, light_b;
  logic       pwm_a, pwm_b, max_a, max_b, min_a, min_b;

  always #5 clk = ~clk;

  light_nlvl_dimmer #(.LEVELS(L), .DEB_CYCLES(DB), .REPEAT_CYCLES(0)) dut_a (
    .clk(clk), .reset(reset), .btn_up(btn_up), .btn_down(btn_down),
    .level(lvl_a), .light(light_a), .pwm_out(pwm_a), .at_max(max_a), .at_min(min_a)
  );

  light_nlvl_dimmer #(.LEVELS(L), .DEB_CYCLES(DB), .REPEAT_CYCLES(RP)) dut_b (
    .clk(clk), .reset(reset), .btn_up(btn_up), .btn_down(btn_down),
    .level(lvl_b), .light(light_b), .pwm_out(pwm_b), .at_max(max_b), .at_min(min_b)
  );

  int n_chk = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d want=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural model: index 0 = up button, 1 = down button; levels per DUT.
  bit s1 [2];
  bit s2 [2];
  bit deb [2];
  bit debq [2];
  bit hist [2][$];
  int m_lvl [2];
  bit m_pwm [2];
  int pcnt;
  bit armed;
  int since;

  task automatic model_reset();
    for (int b = 0; b < 2; b++) begin
      s1[b] = 0; s2[b] = 0; deb[b] = 0; debq[b] = 0;
      hist[b].delete();
      m_lvl[b] = 0; m_pwm[b] = 0;
    end
    pcnt = 0; armed = 0; since = 0;
  endtask

  task automatic model_edge();
    bit up_p, dn_p, alone, tick, up_ev, dn_ev, raw_b, all_diff;
    up_p  = deb[0] && !debq[0];
    dn_p  = deb[1] && !debq[1];
    alone = deb[0] ^ deb[1];
    tick  = armed && alone && !(up_p || dn_p) && ((since + 1) % RP == 0);
    for (int d = 0; d < 2; d++) begin
      up_ev = up_p || (d == 1 && tick && deb[0]);
      dn_ev = dn_p || (d == 1 && tick && deb[1]);
      m_pwm[d] = (pcnt < m_lvl[d]);
      if (up_ev && !dn_ev && m_lvl[d] < L) m_lvl[d]++;
      else if (dn_ev && !up_ev && m_lvl[d] > 0) m_lvl[d]--;
    end
    if (!alone) begin
      armed = 0; since = 0;
    end else if (up_p || dn_p) begin
      armed = 1; since = 0;
    end else if (armed) begin
      since++;
    end
    pcnt = (pcnt + 1) % L;
    for (int b = 0; b < 2; b++) begin
      raw_b = (b == 0) ? btn_up : btn_down;
      debq[b] = deb[b];
      hist[b].push_back(s2[b]);
      if (hist[b].size() > DB) void'(hist[b].pop_front());
      all_diff = (hist[b].size() == DB);
      foreach (hist[b][k]) if (hist[b][k] == deb[b]) all_diff = 0;
      if (all_diff) begin
        deb[b] = !deb[b];
        hist[b].delete();
      end
      s2[b] = s1[b];
      s1[b] = raw_b;
    end
  endtask

  task automatic compare_all();
    chk("lvl_a",   32'(lvl_a),   32'(m_lvl[0]));
    chk("lvl_b",   32'(lvl_b),   32'(m_lvl[1]));
    chk("light_a", 32'(light_a), (32'd1 << m_lvl[0]) - 32'd1);
    chk("light_b", 32'(light_b), (32'd1 << m_lvl[1]) - 32'd1);
    chk("pwm_a",   32'(pwm_a),   32'(m_pwm[0]));
    chk("pwm_b",   32'(pwm_b),   32'(m_pwm[1]));
    chk("max_a",   32'(max_a),   32'(m_lvl[0] == L));
    chk("min_a",   32'(min_a),   32'(m_lvl[0] == 0));
    chk("max_b",   32'(max_b),   32'(m_lvl[1] == L));
    chk("min_b",   32'(min_b),   32'(m_lvl[1] == 0));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
  endtask

  task automatic hold(input bit u, input bit d, input int n);
    btn_up = u; btn_down = d;
    repeat (n) step();
  endtask

  task automatic press(input bit u, input bit d);
    hold(u, d, 10);
    hold(0, 0, 10);
  endtask

  // Called at a falling edge; asserts reset between clock edges.
  task automatic async_reset();
    #2 reset = 1'b1;
    model_reset();
    #1;
    chk("rst_lvl",   32'(lvl_a),   32'd0);
    chk("rst_light", 32'(light_a), 32'd0);
    chk("rst_pwm",   32'(pwm_a),   32'd0);
    chk("rst_min",   32'(min_a),   32'd1);
    chk("rst_max",   32'(max_a),   32'd0);
    chk("rst_lvl_b", 32'(lvl_b),   32'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  int up_exp [5]    = '{1, 2, 3, 4, 4};
  int up_light [5]  = '{1, 3, 7, 15, 15};
  int dn_exp [6]    = '{3, 2, 2, 1, 0, 0};
  bit dn_up [6]     = '{0, 0, 1, 0, 0, 0};
  int ones;

  initial begin
    reset = 1'b1; btn_up = 1'b0; btn_down = 1'b0;
    model_reset();
    @(negedge clk);
    compare_all();
    @(negedge clk);
    reset = 1'b0;

    for (int k = 0; k < 5; k++) begin
      press(1, 0);
      chk("up_seq",   32'(lvl_a),   32'(up_exp[k]));
      chk("up_light", 32'(light_a), 32'(up_light[k]));
      chk("up_max",   32'(max_a),   32'(k >= 3));
    end
    for (int k = 0; k < 6; k++) begin
      press(dn_up[k], 1);
      chk("dn_seq", 32'(lvl_a), 32'(dn_exp[k]));
    end
    chk("dn_min", 32'(min_a), 32'd1);

    // Bounce then steady: one increment, on the 7th edge after steady start.
    hold(1, 0, 2); hold(0, 0, 2); hold(1, 0, 2); hold(0, 0, 2);
    hold(1, 0, 6);
    chk("bounce_early", 32'(lvl_a), 32'd0);
    step();
    chk("bounce_edge7", 32'(lvl_a), 32'd1);
    hold(1, 0, 4); hold(0, 0, 12);
    chk("bounce_once", 32'(lvl_a), 32'd1);
    hold(1, 0, 3); hold(0, 0, 12);
    chk("glitch", 32'(lvl_a), 32'd1);

    // Hold-to-repeat on the repeating instance.
    async_reset();
    hold(1, 0, 50);
    chk("rpt_top", 32'(lvl_b), 32'd4);
    chk("rpt_none_a", 32'(lvl_a), 32'd1);
    hold(1, 1, 40);
    chk("rpt_both", 32'(lvl_b), 32'd3);
    hold(0, 0, 15);

    // PWM duty at level 0, 2 and 4.
    async_reset();
    ones = 0;
    for (int i = 0; i < 8; i++) begin step(); ones += int'(pwm_a); end
    chk("pwm_l0", 32'(ones), 32'd0);
    press(1, 0); press(1, 0);
    ones = 0;
    for (int i = 0; i < 8; i++) begin step(); ones += int'(pwm_a); end
    chk("pwm_l2", 32'(ones), 32'd4);
    press(1, 0); press(1, 0);
    ones = 0;
    for (int i = 0; i < 8; i++) begin step(); ones += int'(pwm_a); end
    chk("pwm_l4", 32'(ones), 32'd8);

    // Reset mid-debounce at level 3; the held button needs full debounce again.
    async_reset();
    press(1, 0); press(1, 0); press(1, 0);
    chk("pre_rst", 32'(lvl_a), 32'd3);
    hold(1, 0, 4);
    async_reset();
    hold(1, 0, 6);
    chk("post_rst_early", 32'(lvl_a), 32'd0);
    step();
    chk("post_rst_inc", 32'(lvl_a), 32'd1);
    hold(0, 0, 12);

    for (int it = 0; it < 600; it++) begin
      if ($urandom_range(0, 59) == 0) async_reset();
      hold(1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0), $urandom_range(1, 14));
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
